// File: rtl/equal_share_arb_pkg.sv
// Shared definitions for the equal-share compare arbiter: FSM state encoding
// and the requester-index width helper.
package equal_share_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // ceil(log2(n)), never below 1 so a 2-requester build still has an id bit
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/equal.sv
// Behavioural model of the library equality macrocell: eq = (a == b)
// over the full operand width.
module equal #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request searching
// upward from last_grant+1 with wrap-around.
module rr_pick
    import equal_share_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        int unsigned k;
        logic [ID_W-1:0] k_idx;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        k_idx = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            k     = (32'(last_grant) + off) % NREQ;
            k_idx = ID_W'(k);
            if (!any && req[k_idx]) begin
                grant[k_idx] = 1'b1;
                idx          = k_idx;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/equal_share_arb.sv
// Round-robin arbiter sharing one equality comparator among NREQ requesters;
// each accepted request yields one registered match result with handshake.
module equal_share_arb
    import equal_share_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned ID_W   = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_match,
    input  logic                   cnt_clear,
    output logic [CNT_W-1:0]       match_cnt
);

    state_t            state, state_nxt;
    logic [NREQ-1:0]   pick_grant;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [ID_W-1:0]   last_grant;
    logic [DATA_W-1:0] a_q, b_q;
    logic              cmp_eq;
    logic              accept;
    logic              deliver;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    equal #(.WIDTH(DATA_W)) u_equal (
        .a  (a_q),
        .b  (b_q),
        .eq (cmp_eq)
    );

    assign accept  = (state == ST_IDLE) && pick_any;
    assign deliver = (state == ST_RSP) && rsp_ready;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        unique case (state)
            ST_IDLE: if (pick_any) begin
                req_ready = pick_grant;
                state_nxt = ST_CMP;
            end
            ST_CMP: state_nxt = ST_RSP;
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // the capture is discarded by reset, so no accept strobe may show either
        if (!rst_n) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(NREQ - 1);
            a_q        <= '0;
            b_q        <= '0;
            rsp_id     <= '0;
            rsp_match  <= 1'b0;
            match_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= req_a[pick_idx*DATA_W +: DATA_W];
                b_q    <= req_b[pick_idx*DATA_W +: DATA_W];
                rsp_id <= pick_idx;
            end
            if (state == ST_CMP) rsp_match <= cmp_eq;
            if (deliver) last_grant <= rsp_id;
            if (cnt_clear)
                match_cnt <= '0;
            else if (deliver && rsp_match && (match_cnt != '1))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_equal_share_arb.sv
// Self-checking bench for equal_share_arb: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_equal_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_match;
    logic        cnt_clear;
    logic [3:0]  match_cnt;

    int total = 0;
    int bad   = 0;
    int m_last;
    int m_cnt;

    equal_share_arb #(.NREQ(4), .DATA_W(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_match (rsp_match),
        .cnt_clear (cnt_clear),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    // reference: first requester above last grant, wrapping
    function automatic int pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= 4; off++) begin
            int k;
            k = (last + off) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return (k < 0) ? 4'b0000 : (one << k);
    endfunction

    function automatic logic [15:0] sa(input int k);
        return req_a[k*16 +: 16];
    endfunction

    function automatic logic [15:0] sb(input int k);
        return req_b[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a;
            a = 16'($urandom);
            req_a[k*16 +: 16] = a;
            req_b[k*16 +: 16] = ($urandom_range(0, 1) == 1) ? a : a ^ (16'd1 << $urandom_range(0, 15));
        end
    endtask

    task automatic deliver_model(input logic m, input int id, input logic clr);
        m_last = id;
        if (clr) m_cnt = 0;
        else if (m && m_cnt < 15) m_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        rand_ops();
        repeat (2) tick();
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        total++; if (rsp_match !== 1'b0) begin bad++; $display("FAIL reset_rsp_match: got %b want 0", rsp_match); end
        total++; if (match_cnt !== 4'd0) begin bad++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt); end
        tick();
        rst_n = 1'b1;
        req_valid = 4'h0;
        m_last = 3;
        m_cnt = 0;
    endtask

    task automatic test_fairness();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        rand_ops();
        for (int g = 0; g < 5; g++) begin
            int exp;
            logic em;
            @(negedge clk);
            exp = pick(req_valid, m_last);
            em = (sa(exp) == sb(exp));
            total++; if (req_ready !== onehot(exp)) begin bad++; $display("FAIL fair_grant%0d: got %b want %b", g, req_ready, onehot(exp)); end
            tick();
            rand_ops();
            @(negedge clk);
            total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin bad++; $display("FAIL fair_cmp%0d: got ready=%b valid=%b want 0000/0", g, req_ready, rsp_valid); end
            tick();
            rand_ops();
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_match !== em) begin bad++; $display("FAIL fair_rsp%0d: got v=%b id=%0d m=%b want 1/%0d/%b", g, rsp_valid, rsp_id, rsp_match, exp, em); end
            tick();
            deliver_model(em, exp, 1'b0);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_single();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        m_cnt = 0;
        rsp_ready = 1'b1;
        rand_ops();
        req_valid = 4'b0001;
        req_a[15:0] = 16'h1234;
        req_b[15:0] = 16'h1234;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_cmp: got ready=%b valid=%b want 0000/0", req_ready, rsp_valid); end
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_match !== 1'b1) begin bad++; $display("FAIL single_rsp: got v=%b id=%0d m=%b want 1/0/1", rsp_valid, rsp_id, rsp_match); end
        tick();
        deliver_model(1'b1, 0, 1'b0);
        @(negedge clk);
        total++; if (match_cnt !== 4'(m_cnt) || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_cnt: got cnt=%0d v=%b want %0d/0", match_cnt, rsp_valid, m_cnt); end
        tick();
    endtask

    task automatic test_mismatch();
        rsp_ready = 1'b1;
        rand_ops();
        req_valid = 4'b0100;
        req_a[47:32] = 16'h00FF;
        req_b[47:32] = 16'h00FE;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mis_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_match !== 1'b0) begin bad++; $display("FAIL mis_rsp: got v=%b id=%0d m=%b want 1/2/0", rsp_valid, rsp_id, rsp_match); end
        tick();
        deliver_model(1'b0, 2, 1'b0);
        @(negedge clk);
        total++; if (match_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL mis_cnt: got %0d want %0d", match_cnt, m_cnt); end
        tick();
    endtask

    task automatic test_backpressure();
        int exp, exp2;
        logic em, em2;
        rsp_ready = 1'b0;
        rand_ops();
        req_valid = 4'b1010;
        @(negedge clk);
        exp = pick(req_valid, m_last);
        em = (sa(exp) == sb(exp));
        total++; if (req_ready !== onehot(exp)) begin bad++; $display("FAIL bp_grant: got %b want %b", req_ready, onehot(exp)); end
        tick();
        req_valid = 4'hF;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_match !== em || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d m=%b r=%b want 1/%0d/%b/0000", i, rsp_valid, rsp_id, rsp_match, req_ready, exp, em); end
            tick();
            rand_ops();
        end
        rsp_ready = 1'b1;
        tick();
        deliver_model(em, exp, 1'b0);
        @(negedge clk);
        exp2 = pick(req_valid, m_last);
        em2 = (sa(exp2) == sb(exp2));
        total++; if (req_ready !== onehot(exp2) || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_next_grant: got r=%b v=%b want %b/0", req_ready, rsp_valid, onehot(exp2)); end
        total++; if (match_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL bp_cnt: got %0d want %0d", match_cnt, m_cnt); end
        tick();
        req_valid = 4'h0;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp2) || rsp_match !== em2) begin bad++; $display("FAIL bp_second_rsp: got v=%b id=%0d m=%b want 1/%0d/%b", rsp_valid, rsp_id, rsp_match, exp2, em2); end
        tick();
        deliver_model(em2, exp2, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        int exp;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        m_cnt = 0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 17; n++) begin
            req_valid = 4'($urandom_range(1, 15));
            rand_ops();
            req_b = req_a;
            @(negedge clk);
            exp = pick(req_valid, m_last);
            total++; if (req_ready !== onehot(exp)) begin bad++; $display("FAIL sat_grant%0d: got %b want %b", n, req_ready, onehot(exp)); end
            tick();
            req_valid = 4'h0;
            tick();
            @(negedge clk);
            total++; if (rsp_id !== 2'(exp) || rsp_match !== 1'b1) begin bad++; $display("FAIL sat_rsp%0d: got id=%0d m=%b want %0d/1", n, rsp_id, rsp_match, exp); end
            tick();
            deliver_model(1'b1, exp, 1'b0);
            @(negedge clk);
            total++; if (match_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", n, match_cnt, m_cnt); end
            tick();
        end
        req_valid = 4'b0001;
        rand_ops();
        req_b = req_a;
        tick();
        req_valid = 4'h0;
        exp = pick(4'b0001, m_last);
        tick();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        deliver_model(1'b1, exp, 1'b1);
        @(negedge clk);
        total++; if (match_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL clear_vs_inc: got %0d want %0d", match_cnt, m_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        rand_ops();
        @(negedge clk);
        total++; if (req_ready !== onehot(pick(4'hF, m_last))) begin bad++; $display("FAIL rmid_grant: got %b want %b", req_ready, onehot(pick(4'hF, m_last))); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_last = 3;
        m_cnt = 0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || match_cnt !== 4'd0) begin bad++; $display("FAIL rmid_abandon: got v=%b cnt=%0d want 0/0", rsp_valid, match_cnt); end
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_regrant: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'h0;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin bad++; $display("FAIL rmid_rsp: got v=%b id=%0d want 1/0", rsp_valid, rsp_id); end
        deliver_model(rsp_match, 0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_random();
        int mode = 0;
        int eid = 0;
        logic em = 1'b0;
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            rand_ops();
            rsp_ready = ($urandom_range(0, 2) != 0);
            cnt_clear = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            total++; if (match_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, match_cnt, m_cnt); end
            if (mode == 0) begin
                int exp;
                exp = pick(req_valid, m_last);
                total++; if (req_ready !== onehot(exp) || rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle@%0d: got r=%b v=%b want %b/0", c, req_ready, rsp_valid, onehot(exp)); end
                if (exp >= 0) begin
                    eid = exp;
                    em = (sa(exp) == sb(exp));
                    mode = 1;
                end
                if (cnt_clear) m_cnt = 0;
            end else if (mode == 1) begin
                total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rnd_cmp@%0d: got r=%b v=%b want 0000/0", c, req_ready, rsp_valid); end
                mode = 2;
                if (cnt_clear) m_cnt = 0;
            end else begin
                total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(eid) || rsp_match !== em || req_ready !== 4'b0000) begin bad++; $display("FAIL rnd_rsp@%0d: got v=%b id=%0d m=%b r=%b want 1/%0d/%b/0000", c, rsp_valid, rsp_id, rsp_match, req_ready, eid, em); end
                if (rsp_ready) begin
                    deliver_model(em, eid, cnt_clear);
                    mode = 0;
                end else if (cnt_clear) begin
                    m_cnt = 0;
                end
            end
            tick();
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        cnt_clear = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'h0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        cnt_clear = 1'b0;
        m_last = 3;
        m_cnt = 0;
        test_reset();
        test_fairness();
        test_single();
        test_mismatch();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/equal_share_arb.md
EQUAL_SHARE_ARB -- requirements
Module: equal_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_W, default 16: operand width in bits.
REQ-003 Parameter CNT_W, default 16: match-counter width in bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-requester compare request.
REQ-007 req_ready  output  NREQ  one-hot accept strobe, at most one bit high per cycle.
REQ-008 req_a  input  NREQ*DATA_W  operand A; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-009 req_b  input  NREQ*DATA_W  operand B; same packing as req_a.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_match  output  1  1 when A == B for that request.
REQ-014 cnt_clear  input  1  synchronous clear of match_cnt.
REQ-015 match_cnt  output  CNT_W  count of delivered results with rsp_match = 1.

Function
REQ-016 FSM states: IDLE, CMP, RSP; state encoding is in the shared package.
REQ-017 IDLE, any req_valid high: grant the first asserted requester searching from (last_grant+1) mod NREQ upward, with wrap-around.
REQ-018 Grant cycle: assert req_ready[winner] for exactly one cycle, capture req_a/req_b slices and the winner index into registers, go to CMP.
REQ-019 IDLE, no req_valid high: stay in IDLE; req_ready = 0.
REQ-020 CMP: register the single shared comparator output (captured A == captured B) into rsp_match, go to RSP; exactly one comparator instance serves all requesters.
REQ-021 RSP: rsp_valid = 1; rsp_id and rsp_match stay stable until rsp_ready = 1.
REQ-022 RSP with rsp_ready = 1: update last_grant to rsp_id, increment match_cnt if rsp_match = 1, go to IDLE.
REQ-023 Latency: accept in cycle N, rsp_valid first high in cycle N+2; with rsp_ready held high, peak throughput is one result per 3 cycles.
REQ-024 req_ready stays 0 in CMP and RSP; requests arriving then wait and are not dropped.
REQ-025 A requester that drops req_valid before it is granted is not served.
REQ-026 match_cnt saturates at all-ones and does not wrap.
REQ-027 cnt_clear and an increment in the same cycle: the clear wins and match_cnt becomes 0.
REQ-028 rsp_match is a full DATA_W-bit equality; there is no partial or masked compare.

Reset
REQ-029 When rst_n = 0 at a clock edge: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_match = 0, rsp_id = 0, match_cnt = 0, last_grant = NREQ-1 (so requester 0 has first priority).
REQ-030 Reset asserted in CMP or RSP abandons the pending result; no rsp_valid pulse follows reset release, and match_cnt is not incremented.

Structure
REQ-031 A shared package holds the FSM state typedef/constants and the clog2-derived id-width function.
REQ-032 Sub-module rr_pick: combinational round-robin selector with inputs (req vector, last_grant) and outputs (one-hot grant, index, any).
REQ-033 The comparison uses the library `equal` macrocell, instantiated once with width = DATA_W.

Verification
REQ-034 Single request: req_valid = 0001, A = B = 16'h1234 -> req_ready = 0001 for one cycle; rsp_valid two cycles later with rsp_id = 0, rsp_match = 1; match_cnt = 1.
REQ-035 Mismatch: requester 2 sends A = 16'h00FF, B = 16'h00FE -> rsp_id = 2, rsp_match = 0; match_cnt unchanged.
REQ-036 Fairness: req_valid = 1111 held, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0; one result every 3 cycles.
REQ-037 Backpressure: rsp_ready = 0 for 5 cycles in RSP -> rsp_valid, rsp_id, rsp_match stable; req_ready = 0 throughout; on release the next grant follows on the next IDLE cycle.
REQ-038 Saturation/clear: CNT_W = 4, deliver 17 matches -> match_cnt = 15; cnt_clear in the same cycle as a match -> match_cnt = 0.
REQ-039 Reset mid-op: rst_n = 0 for 1 cycle while in CMP -> IDLE, rsp_valid stays 0, next grant goes to requester 0.
